// File: rtl/mux_scan_capture.sv
// Scan sequencer around an 8:1 mux stage: steps sel, captures mux_o bit by bit, hands the word out on valid/ready.
// Optional feature: define SCAN_PARITY_EN to add the registered parity output.
module mux_scan_capture #(
    parameter int SEL_W  = 3,
    parameter int SETTLE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mux_o,
    output logic [SEL_W-1:0]      sel,
    output logic [(2**SEL_W)-1:0] data,
    output logic                  valid,
    input  logic                  out_ready,
    output logic                  busy
`ifdef SCAN_PARITY_EN
    ,
    output logic                  parity
`endif
);

    localparam int N = 2 ** SEL_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg;
    logic [SEL_W-1:0]   sel_reg;
    logic [N-1:0]       data_reg;
    logic [N-1:0]       shadow_reg;
    logic [N-1:0]       shadow_next;
    logic [3:0]         cnt_reg;
    logic               valid_reg;
    logic               busy_reg;
    logic               last_sel;
    logic               cnt_zero;

    // Shadow word with the bit currently being captured already merged in.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_merge
            assign shadow_next[gi] = (sel_reg == SEL_W'(gi)) ? mux_o : shadow_reg[gi];
        end
    endgenerate

    assign last_sel = (sel_reg == SEL_W'(N - 1));
    assign cnt_zero = (cnt_reg == 4'd0);

`ifdef SCAN_PARITY_EN
    logic parity_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_reg <= 1'b0;
        end else if (state_reg == SCAN && cnt_zero && last_sel) begin
            parity_reg <= ^shadow_next;
        end
    end
    assign parity = parity_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            sel_reg    <= '0;
            data_reg   <= '0;
            shadow_reg <= '0;
            cnt_reg    <= 4'd0;
            valid_reg  <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg  <= SCAN;
                        sel_reg    <= '0;
                        cnt_reg    <= 4'(SETTLE);
                        shadow_reg <= '0;
                        busy_reg   <= 1'b1;
                    end
                end
                SCAN: begin
                    if (!cnt_zero) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        shadow_reg <= shadow_next;
                        if (last_sel) begin
                            state_reg <= DONE;
                            data_reg  <= shadow_next;
                            valid_reg <= 1'b1;
                            busy_reg  <= 1'b0;
                        end else begin
                            sel_reg <= sel_reg + SEL_W'(1);
                            cnt_reg <= 4'(SETTLE);
                        end
                    end
                end
                DONE: begin
                    // The word stays put until downstream takes it; start alone cannot restart.
                    if (valid_reg && out_ready) begin
                        valid_reg <= 1'b0;
                        sel_reg   <= '0;
                        if (start) begin
                            state_reg  <= SCAN;
                            cnt_reg    <= 4'(SETTLE);
                            shadow_reg <= '0;
                            busy_reg   <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    sel_reg   <= '0;
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign sel   = sel_reg;
    assign data  = data_reg;
    assign valid = valid_reg;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_mux_scan_capture.sv
// Directed bench: two sequencer instances (SETTLE=0 and SETTLE=2), each driving a modelled 8:1 mux.
module tb_mux_scan_capture;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0, start2 = 1'b0;
    logic       ready0 = 1'b1, ready2 = 1'b1;
    logic [7:0] inp0 = 8'h00, inp2 = 8'h00;
    logic [2:0] sel0, sel2;
    logic [7:0] data0, data2;
    logic       valid0, valid2, busy0, busy2;
    logic       mux_o0, mux_o2;
`ifdef SCAN_PARITY_EN
    logic       parity0, parity2;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // 8:1 mux stage model
    assign mux_o0 = inp0[sel0];
    assign mux_o2 = inp2[sel2];

    mux_scan_capture #(.SEL_W(3), .SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .mux_o(mux_o0),
        .sel(sel0), .data(data0), .valid(valid0), .out_ready(ready0), .busy(busy0)
`ifdef SCAN_PARITY_EN
        , .parity(parity0)
`endif
    );

    mux_scan_capture #(.SEL_W(3), .SETTLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mux_o(mux_o2),
        .sel(sel2), .data(data2), .valid(valid2), .out_ready(ready2), .busy(busy2)
`ifdef SCAN_PARITY_EN
        , .parity(parity2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Pulse start on dut0, then count edges until valid (bounded).
    task automatic scan0(input logic [7:0] v, input logic hold_start, output int n);
        inp0 = v;
        start0 = 1'b1;
        @(negedge clk);
        if (!hold_start) start0 = 1'b0;
        n = 0;
        while (!valid0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        $display("scan0 inp=%h data=%h cycles=%0d", v, data0, n);
    endtask

    initial begin
        int n;
        // Reset state
        #2;
        check("rst_sel", 32'(sel0), 0);
        check("rst_data", 32'(data0), 0);
        check("rst_valid", 32'(valid0), 0);
        check("rst_busy", 32'(busy0), 0);
`ifdef SCAN_PARITY_EN
        check("rst_parity", 32'(parity0), 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: 0x55, one-cycle start, sel steps every cycle
        inp0 = 8'h55;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t1_sel%0d", k), 32'(sel0), 32'(k));
            check($sformatf("t1_busy%0d", k), 32'(busy0), 1);
            check($sformatf("t1_novalid%0d", k), 32'(valid0), 0);
            @(negedge clk);
        end
        check("t1_valid", 32'(valid0), 1);
        check("t1_data", 32'(data0), 32'h55);
        check("t1_sel_done", 32'(sel0), 7);
        check("t1_busy_done", 32'(busy0), 0);
`ifdef SCAN_PARITY_EN
        check("t1_parity", 32'(parity0), 32'(^8'h55));
`endif
        $display("scan0 inp=55 data=%h", data0);
        @(negedge clk);
        check("t1_accept_valid", 32'(valid0), 0);
        check("t1_accept_sel", 32'(sel0), 0);
        check("t1_keep_data", 32'(data0), 32'h55);

        // 2: downstream stalls 5 cycles, start pulses must not disturb the word
        ready0 = 1'b0;
        scan0(8'h55, 1'b0, n);
        check("t2_latency", 32'(n), 8);
        for (int i = 0; i < 5; i++) begin
            start0 = i[0];
            @(negedge clk);
            check($sformatf("t2_hold_valid%0d", i), 32'(valid0), 1);
            check($sformatf("t2_hold_data%0d", i), 32'(data0), 32'h55);
            check($sformatf("t2_hold_busy%0d", i), 32'(busy0), 0);
        end
        start0 = 1'b0;
        ready0 = 1'b1;
        @(negedge clk);
        check("t2_accept_valid", 32'(valid0), 0);
        check("t2_accept_sel", 32'(sel0), 0);
        @(negedge clk);
        check("t2_idle_busy", 32'(busy0), 0);

        // 3: start held, back-to-back scans with no idle cycle
        scan0(8'h55, 1'b1, n);
        check("t3_first_data", 32'(data0), 32'h55);
        inp0 = 8'hA3;
        @(negedge clk);
        check("t3_turn_busy", 32'(busy0), 1);
        check("t3_turn_valid", 32'(valid0), 0);
        check("t3_turn_sel", 32'(sel0), 0);
        start0 = 1'b0;
        n = 0;
        while (!valid0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        $display("scan0 inp=a3 data=%h cycles=%0d", data0, n);
        check("t3_latency", 32'(n), 8);
        check("t3_data", 32'(data0), 32'hA3);
`ifdef SCAN_PARITY_EN
        check("t3_parity", 32'(parity0), 32'(^8'hA3));
`endif
        @(negedge clk);

        // 4: SETTLE=2 instance, each sel held three cycles
        inp2 = 8'hF0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int j = 0; j < 24; j++) begin
            check($sformatf("t4_sel_e%0d", j), 32'(sel2), 32'(j / 3));
            check($sformatf("t4_novalid_e%0d", j), 32'(valid2), 0);
            @(negedge clk);
        end
        $display("scan2 inp=f0 data=%h", data2);
        check("t4_valid", 32'(valid2), 1);
        check("t4_data", 32'(data2), 32'hF0);
        @(negedge clk);

        // 5: reset mid-scan at sel=4
        inp0 = 8'h5A;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge clk);
        check("t5_pre_sel", 32'(sel0), 4);
        rst_n = 1'b0;
        #1;
        check("t5_rst_sel", 32'(sel0), 0);
        check("t5_rst_busy", 32'(busy0), 0);
        check("t5_rst_valid", 32'(valid0), 0);
        check("t5_rst_data", 32'(data0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_no_pulse", 32'(valid0), 0);
        scan0(8'h3C, 1'b0, n);
        check("t5_latency", 32'(n), 8);
        check("t5_data", 32'(data0), 32'h3C);
        @(negedge clk);

        // 6: start during SCAN at sel=3 is ignored
        inp0 = 8'hC6;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int k = 0; k < 3; k++) @(negedge clk);
        check("t6_sel3", 32'(sel0), 3);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("t6_sel4", 32'(sel0), 4);
        n = 4;
        while (!valid0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        $display("scan0 inp=c6 data=%h cycles=%0d", data0, n);
        check("t6_latency", 32'(n), 8);
        check("t6_data", 32'(data0), 32'hC6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
